// File: rtl/cam_way_select.sv
// Victim-way selector for the 4-way ToeCam insert path: lowest free way first,
// otherwise round-robin probe from the random index. Optional stats: CAM_WAY_SEL_STATS_EN.
module cam_way_select #(
  parameter int NUM_WAYS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [SEL_W-1:0]    Mod,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic [NUM_WAYS-1:0] ReqWayValid,
  input  logic [NUM_WAYS-1:0] ReqWayLock,
  output logic                GntValid,
  input  logic                GntReady,
  output logic [SEL_W-1:0]    GntWay,
  output logic                GntEvict,
  output logic                GntFail
`ifdef CAM_WAY_SEL_STATS_EN
  ,
  output logic [15:0]         EvictCnt,
  output logic [15:0]         FailCnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHOOSE = 2'd1,
    PROBE  = 2'd2,
    GRANT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [SEL_W-1:0]    cnt_q, cnt_d;
  logic [NUM_WAYS-1:0] vq_q, vq_d;
  logic [NUM_WAYS-1:0] lq_q, lq_d;
  logic                req_ready_q, req_ready_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic [SEL_W-1:0]    gnt_way_q, gnt_way_d;
  logic                gnt_evict_q, gnt_evict_d;
  logic                gnt_fail_q, gnt_fail_d;

  logic                free_found;
  logic [SEL_W-1:0]    free_idx;
  logic                gnt_hs;

  // Descending scan so the last hit, i.e. the lowest free index, wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!vq_q[i]) begin
        free_found = 1'b1;
        free_idx   = SEL_W'(i);
      end
    end
  end

  assign gnt_hs = (state_q == GRANT) && gnt_valid_q && GntReady;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    vq_d        = vq_q;
    lq_d        = lq_q;
    req_ready_d = req_ready_q;
    gnt_valid_d = gnt_valid_q;
    gnt_way_d   = gnt_way_q;
    gnt_evict_d = gnt_evict_q;
    gnt_fail_d  = gnt_fail_q;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (ReqValid && req_ready_q) begin
          vq_d        = ReqWayValid;
          lq_d        = ReqWayLock;
          req_ready_d = 1'b0;
          state_d     = CHOOSE;
        end
      end
      CHOOSE: begin
        if (free_found) begin
          gnt_way_d   = free_idx;
          gnt_evict_d = 1'b0;
          gnt_fail_d  = 1'b0;
          state_d     = GRANT;
        end else begin
          ptr_d   = Mod;
          cnt_d   = '0;
          state_d = PROBE;
        end
      end
      PROBE: begin
        if (!lq_q[ptr_q]) begin
          gnt_way_d   = ptr_q;
          gnt_evict_d = 1'b1;
          gnt_fail_d  = 1'b0;
          state_d     = GRANT;
        end else if (cnt_q == SEL_W'(NUM_WAYS - 1)) begin
          gnt_way_d   = '0;
          gnt_evict_d = 1'b0;
          gnt_fail_d  = 1'b1;
          state_d     = GRANT;
        end else begin
          ptr_d = ptr_q + SEL_W'(1);
          cnt_d = cnt_q + SEL_W'(1);
        end
      end
      GRANT: begin
        if (gnt_hs) begin
          gnt_valid_d = 1'b0;
          gnt_evict_d = 1'b0;
          gnt_fail_d  = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          gnt_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      vq_q        <= '0;
      lq_q        <= '0;
      req_ready_q <= 1'b0;
      gnt_valid_q <= 1'b0;
      gnt_way_q   <= '0;
      gnt_evict_q <= 1'b0;
      gnt_fail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      vq_q        <= vq_d;
      lq_q        <= lq_d;
      req_ready_q <= req_ready_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_way_q   <= gnt_way_d;
      gnt_evict_q <= gnt_evict_d;
      gnt_fail_q  <= gnt_fail_d;
    end
  end

  assign ReqReady = req_ready_q;
  assign GntValid = gnt_valid_q;
  assign GntWay   = gnt_way_q;
  assign GntEvict = gnt_evict_q;
  assign GntFail  = gnt_fail_q;

`ifdef CAM_WAY_SEL_STATS_EN
  logic [15:0] evict_cnt_q, fail_cnt_q;

  // Saturating event counters, bumped only on the grant handshake.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      evict_cnt_q <= '0;
      fail_cnt_q  <= '0;
    end else if (gnt_hs) begin
      if (gnt_evict_q && (evict_cnt_q != 16'hFFFF)) evict_cnt_q <= evict_cnt_q + 16'd1;
      if (gnt_fail_q && (fail_cnt_q != 16'hFFFF))   fail_cnt_q  <= fail_cnt_q + 16'd1;
    end
  end

  assign EvictCnt = evict_cnt_q;
  assign FailCnt  = fail_cnt_q;
`endif

endmodule
